// File: rtl/text_console_writer.sv
// text_console_writer: turns an ASCII byte stream into VRAM cell writes.
// Tracks cursor and attribute; blanks lines and the screen on demand.
module text_console_writer #(
  parameter int         COLS_WIDE    = 50,
  parameter int         ROWS_WIDE    = 15,
  parameter int         COLS_TALL    = 30,
  parameter int         ROWS_TALL    = 25,
  parameter logic [7:0] DEFAULT_ATTR = 8'h0F
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [1:0]  direction,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        attr_we,
  input  logic [7:0]  attr_in,
  input  logic        clear_req,
  output logic        busy,
  output logic        ram_ce,
  output logic [11:0] ram_addr,
  output logic [15:0] ram_data,
  output logic [7:0]  cursor_col,
  output logic [7:0]  cursor_row
);
  typedef enum logic [1:0] {IDLE, WRITE, CLEAR_LINE, CLEAR_ALL} state_t;

  state_t      state, state_d;
  logic        tall, tall_q, geo, geo_d;
  logic        pending, pending_d, nl, nl_d;
  logic [9:0]  cnt, cnt_d;
  logic [7:0]  attr, fill_attr, fill_attr_d;
  logic [7:0]  col_d, row_d, nl_row;
  logic        ram_ce_d, in_ready_d, busy_d;
  logic [11:0] ram_addr_d;
  logic [15:0] ram_data_d, blank;
  logic [9:0]  cols, rows, total, base, cur_addr, nl_base;
  logic        last_col, last_row, accept;
  logic        is_print, is_cr, is_lf, is_bs, is_ff;

  assign tall     = (direction == 2'd1) || (direction == 2'd3);
  assign cols     = geo ? 10'(COLS_TALL) : 10'(COLS_WIDE);
  assign rows     = geo ? 10'(ROWS_TALL) : 10'(ROWS_WIDE);
  assign total    = (state == CLEAR_ALL) ? cols * rows : cols;
  assign base     = 10'(cursor_row) * cols;
  assign cur_addr = base + 10'(cursor_col);
  assign last_col = 10'(cursor_col) == cols - 10'd1;
  assign last_row = 10'(cursor_row) == rows - 10'd1;
  assign nl_row   = last_row ? 8'd0 : cursor_row + 8'd1;
  assign nl_base  = 10'(nl_row) * cols;
  assign blank    = {attr, 8'h20};

  // tall_q lags direction by one cycle so in_ready never promises a byte
  // in the same cycle a geometry change is acted on
  assign accept   = in_valid && in_ready && (tall_q == geo) && !pending;

  assign is_print = (in_data >= 8'h20) && (in_data <= 8'h7E);
  assign is_cr    = in_data == 8'h0D;
  assign is_lf    = in_data == 8'h0A;
  assign is_bs    = in_data == 8'h08;
  assign is_ff    = in_data == 8'h0C;

  always_comb begin
    state_d     = state;
    geo_d       = geo;
    pending_d   = pending || clear_req;
    nl_d        = nl;
    cnt_d       = cnt;
    fill_attr_d = fill_attr;
    col_d       = cursor_col;
    row_d       = cursor_row;
    ram_ce_d    = 1'b0;
    ram_addr_d  = ram_addr;
    ram_data_d  = ram_data;
    case (state)
      IDLE: begin
        if ((tall_q != geo) || pending) begin
          geo_d       = tall_q;
          col_d       = 8'd0;
          row_d       = 8'd0;
          state_d     = CLEAR_ALL;
          pending_d   = 1'b0;
          ram_ce_d    = 1'b1;
          ram_addr_d  = 12'd0;
          ram_data_d  = blank;
          cnt_d       = 10'd1;
          fill_attr_d = attr;
        end else if (accept) begin
          unique case (1'b1)
            is_print: begin
              state_d    = WRITE;
              ram_ce_d   = 1'b1;
              ram_addr_d = {2'b00, cur_addr};
              ram_data_d = {attr, 1'b0, in_data[6:0]};
              nl_d       = last_col;
              col_d      = last_col ? 8'd0 : cursor_col + 8'd1;
              row_d      = last_col ? nl_row : cursor_row;
            end
            is_cr: col_d = 8'd0;
            is_lf: begin
              col_d       = 8'd0;
              row_d       = nl_row;
              state_d     = CLEAR_LINE;
              ram_ce_d    = 1'b1;
              ram_addr_d  = {2'b00, nl_base};
              ram_data_d  = blank;
              cnt_d       = 10'd1;
              fill_attr_d = attr;
            end
            is_bs: begin
              if (cursor_col != 8'd0) begin
                col_d      = cursor_col - 8'd1;
                state_d    = WRITE;
                nl_d       = 1'b0;
                ram_ce_d   = 1'b1;
                ram_addr_d = {2'b00, cur_addr - 10'd1};
                ram_data_d = blank;
              end
            end
            is_ff: pending_d = 1'b1;
            default: ;
          endcase
        end
      end
      WRITE: begin
        if (nl) begin
          // cursor already sits at column 0 of the freshly opened row
          state_d     = CLEAR_LINE;
          nl_d        = 1'b0;
          ram_ce_d    = 1'b1;
          ram_addr_d  = {2'b00, base};
          ram_data_d  = blank;
          cnt_d       = 10'd1;
          fill_attr_d = attr;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        if (cnt == total) begin
          state_d = IDLE;
        end else begin
          ram_ce_d   = 1'b1;
          ram_addr_d = (state == CLEAR_ALL) ? {2'b00, cnt}
                                            : {2'b00, base + cnt};
          ram_data_d = {fill_attr, 8'h20};
          cnt_d      = cnt + 10'd1;
        end
      end
    endcase
    in_ready_d = (state_d == IDLE) && !pending_d && (tall == geo_d);
    busy_d     = (state_d == CLEAR_LINE) || (state_d == CLEAR_ALL);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= CLEAR_ALL;
      geo        <= tall;
      tall_q     <= tall;
      pending    <= 1'b0;
      nl         <= 1'b0;
      cnt        <= 10'd0;
      attr       <= DEFAULT_ATTR;
      fill_attr  <= DEFAULT_ATTR;
      cursor_col <= 8'd0;
      cursor_row <= 8'd0;
      ram_ce     <= 1'b0;
      ram_addr   <= 12'd0;
      ram_data   <= 16'd0;
      in_ready   <= 1'b0;
      busy       <= 1'b1;
    end else begin
      state      <= state_d;
      geo        <= geo_d;
      tall_q     <= tall;
      pending    <= pending_d;
      nl         <= nl_d;
      cnt        <= cnt_d;
      fill_attr  <= fill_attr_d;
      cursor_col <= col_d;
      cursor_row <= row_d;
      ram_ce     <= ram_ce_d;
      ram_addr   <= ram_addr_d;
      ram_data   <= ram_data_d;
      in_ready   <= in_ready_d;
      busy       <= busy_d;
      if (attr_we) attr <= attr_in;
    end
  end
endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: screen model feeds an expected-write
// queue; a negedge monitor pops and compares every VRAM write.
module tb_text_console_writer;
  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  direction = 2'd0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        attr_we = 1'b0;
  logic [7:0]  attr_in = 8'd0;
  logic        clear_req = 1'b0;
  logic        busy, ram_ce;
  logic [11:0] ram_addr;
  logic [15:0] ram_data;
  logic [7:0]  cursor_col, cursor_row;

  int checks = 0;
  int errors = 0;
  logic [27:0] exp_q[$];
  logic [27:0] mon_e;
  int mcol, mrow, mcols, mrows;
  logic [7:0] mattr;
  bit mtall;

  always #5 clk_sys = ~clk_sys;

  text_console_writer dut (
    .clk_sys(clk_sys), .reset(reset), .direction(direction),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .attr_we(attr_we), .attr_in(attr_in), .clear_req(clear_req),
    .busy(busy), .ram_ce(ram_ce), .ram_addr(ram_addr),
    .ram_data(ram_data), .cursor_col(cursor_col),
    .cursor_row(cursor_row)
  );

  // screen model
  function automatic void push(int addr, logic [15:0] data);
    exp_q.push_back({12'(addr), data});
  endfunction

  function automatic void set_geo(bit t);
    mtall = t;
    mcols = t ? 30 : 50;
    mrows = t ? 25 : 15;
  endfunction

  function automatic void fill_all();
    for (int a = 0; a < mcols * mrows; a++) push(a, {mattr, 8'h20});
    mcol = 0;
    mrow = 0;
  endfunction

  function automatic void newline();
    mcol = 0;
    mrow = (mrow + 1) % mrows;
    for (int c = 0; c < mcols; c++) push(mrow * mcols + c, {mattr, 8'h20});
  endfunction

  function automatic void model_byte(logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      push(mrow * mcols + mcol, {mattr, 1'b0, b[6:0]});
      mcol++;
      if (mcol == mcols) newline();
    end else if (b == 8'h0D) begin
      mcol = 0;
    end else if (b == 8'h0A) begin
      newline();
    end else if (b == 8'h08) begin
      if (mcol > 0) begin
        mcol--;
        push(mrow * mcols + mcol, {mattr, 8'h20});
      end
    end else if (b == 8'h0C) begin
      fill_all();
    end
  endfunction

  always @(negedge clk_sys) begin
    if (!reset && ram_ce) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL vram_write: got addr %0d data %h, none expected",
                 ram_addr, ram_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({ram_addr, ram_data} != mon_e) begin
          errors++;
          $display("FAIL vram_write: got addr %0d data %h, expected addr %0d data %h",
                   ram_addr, ram_data, mon_e[27:16], mon_e[15:0]);
        end
      end
    end
  end

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_cursor();
    check("cursor_col", int'(cursor_col), mcol);
    check("cursor_row", int'(cursor_row), mrow);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (!in_ready && n < 3000);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: in_ready got 0 expected 1");
    end
  endtask

  task automatic send_byte(logic [7:0] b);
    int n = 0;
    @(negedge clk_sys);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 3000) begin
      @(negedge clk_sys);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1 for byte %h", b);
      in_valid = 1'b0;
      return;
    end
    model_byte(b);
    @(posedge clk_sys);
    #1 in_valid = 1'b0;
  endtask

  task automatic set_attr(logic [7:0] a);
    wait_idle();
    attr_we = 1'b1;
    attr_in = a;
    mattr   = a;
    @(negedge clk_sys);
    attr_we = 1'b0;
  endtask

  task automatic set_dir(logic [1:0] d);
    bit t;
    wait_idle();
    direction = d;
    t = (d == 2'd1) || (d == 2'd3);
    if (t != mtall) begin
      set_geo(t);
      fill_all();
    end
    @(negedge clk_sys);
  endtask

  task automatic pulse_clear();
    @(negedge clk_sys);
    clear_req = 1'b1;
    fill_all();
    @(negedge clk_sys);
    clear_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    reset = 1'b1;
    @(posedge clk_sys);
    #1 exp_q.delete();
    @(negedge clk_sys);
    check("rst_ram_ce", int'(ram_ce), 0);
    check("rst_ram_addr", int'(ram_addr), 0);
    check("rst_ram_data", int'(ram_data), 0);
    check("rst_busy", int'(busy), 1);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_cursor", int'({cursor_row, cursor_col}), 0);
    mattr = 8'h0F;
    set_geo((direction == 2'd1) || (direction == 2'd3));
    fill_all();
    reset = 1'b0;
  endtask

  initial begin
    int r;
    mattr = 8'h0F;
    set_geo(1'b0);
    repeat (3) @(negedge clk_sys);
    do_reset();
    @(negedge clk_sys);
    check("busy_in_fill", int'(busy), 1);
    wait_idle();
    check_cursor();
    check("busy_idle", int'(busy), 0);

    set_attr(8'h1E);
    send_byte(8'h41);
    wait_idle();
    check("cursor_after_A", int'(cursor_col), 1);
    check_cursor();

    send_byte(8'h0D);
    repeat (14) send_byte(8'h0A);
    repeat (49) send_byte(8'h78);
    wait_idle();
    check("cursor_49_14", int'({cursor_row, cursor_col}), {16'd0, 8'd14, 8'd49});
    send_byte(8'h5A);
    wait_idle();
    check_cursor();

    repeat (3) send_byte(8'h0A);
    repeat (5) send_byte(8'h2E);
    send_byte(8'h08);
    wait_idle();
    check_cursor();
    send_byte(8'h0D);
    send_byte(8'h08);
    wait_idle();
    check_cursor();

    set_dir(2'd1);
    wait_idle();
    check_cursor();
    repeat (29) send_byte(8'h2D);
    send_byte(8'h42);
    wait_idle();
    check_cursor();

    send_byte(8'h0A);
    repeat (2) @(negedge clk_sys);
    check("busy_line", int'(busy), 1);
    pulse_clear();
    send_byte(8'h43);
    wait_idle();
    check_cursor();

    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70) send_byte(8'($urandom_range(32, 126)));
      else if (r < 76) send_byte(8'h0D);
      else if (r < 84) send_byte(8'h0A);
      else if (r < 90) send_byte(8'h08);
      else if (r < 92) send_byte(8'h0C);
      else if (r < 94) send_byte(8'($urandom_range(127, 255)));
      else if (r < 97) set_attr(8'($urandom));
      else if (r < 99) set_dir(2'($urandom_range(0, 3)));
      else pulse_clear();
      wait_idle();
      check_cursor();
    end

    send_byte(8'h0C);
    repeat (20) @(negedge clk_sys);
    do_reset();
    wait_idle();
    check_cursor();
    send_byte(8'h51);
    wait_idle();
    check_cursor();

    repeat (3) @(negedge clk_sys);
    check("pending_writes", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
Upstream feeder for the LCD text-mode display. It accepts a byte stream of ASCII characters and control codes and maintains a cursor. It writes 16-bit character cells {attr[7:0], 1'b0, char[6:0]} into write port A of the display's text VRAM. Screen geometry follows the display rotation input, so the cell layout matches what the display stage reads (row-major, address = row*cols + col).

Parameters:
COLS_WIDE, 50, columns when direction is 0 or 2
ROWS_WIDE, 15, rows when direction is 0 or 2
COLS_TALL, 30, columns when direction is 1 or 3
ROWS_TALL, 25, rows when direction is 1 or 3
DEFAULT_ATTR, 8'h0F, attribute loaded at reset {bg[3:0], fg[3:0]}

Ports:
clk_sys  in  1  system clock; also drives VRAM port A clock
reset  in  1  synchronous, active-high reset
direction  in  2  display rotation; selects geometry
in_valid  in  1  input byte valid
in_data  in  8  input byte
in_ready  out  1  block can accept a byte this cycle
attr_we  in  1  load attr_in into the current attribute
attr_in  in  8  new attribute {bg, fg}
clear_req  in  1  one-cycle pulse; clear screen and home cursor
busy  out  1  a fill (line or full-screen clear) is in progress
ram_ce  out  1  VRAM write enable, one cycle per cell
ram_addr  out  12  VRAM cell address; bits [11:10] always 0
ram_data  out  16  VRAM cell data
cursor_col  out  8  current cursor column
cursor_row  out  8  current cursor row

Behaviour:
- Single clock domain. All outputs are registered.
- Reset values while reset is high: ram_ce=0, ram_addr=0, ram_data=0, in_ready=0, busy=1, cursor=(0,0), attr=DEFAULT_ATTR, clear_pending=0.
- First cycle after reset release: enter CLEAR_ALL.
- FSM states: IDLE, WRITE, CLEAR_LINE, CLEAR_ALL.
- in_ready is 1 only in IDLE with no pending clear and no geometry change. A byte is accepted when in_valid && in_ready.
- IDLE priority, highest first:
  - geometry change (direction class 0/2 vs 1/3 differs from the latched class) -> latch the new geometry, home the cursor, CLEAR_ALL;
  - clear_pending -> home the cursor, CLEAR_ALL;
  - accepted byte.
- clear_req pulses set clear_pending in any state. clear_pending is cleared on entry to CLEAR_ALL.
- Attribute: attr_we updates attr in any cycle. Character writes use attr as sampled in the accept cycle. Fills use attr as sampled on fill entry.
- Byte handling (byte accepted in cycle N):
  - 0x20-0x7E: cycle N+1 is WRITE with ram_ce=1, ram_addr=row*cols+col, ram_data={attr,1'b0,in_data[6:0]}. The cursor then advances one column. If col==cols-1, perform a newline instead.
  - 0x0D (CR): col=0. No write. Returns to IDLE at N+1.
  - 0x0A (LF): newline.
  - 0x08 (BS): if col>0, col-1 and write a space (0x20) at the new position through WRITE. At col=0: no-op.
  - 0x0C (FF): same as clear_req.
  - All other bytes are consumed and ignored; no write.
- Newline: col=0, row=row+1. If row==rows-1, row wraps to 0 (no scrolling). Then CLEAR_LINE the new row.
- CLEAR_LINE: exactly cols consecutive cycles of ram_ce=1, addresses row*cols .. row*cols+cols-1, data {attr,8'h20}. Then IDLE.
- CLEAR_ALL: exactly cols*rows (750) consecutive ram_ce cycles, addresses 0..749 ascending, data {attr,8'h20}. Then IDLE.
- busy=1 throughout CLEAR_LINE and CLEAR_ALL, else 0.
- Throughput: a printable character costs 2 cycles (accept, write). A character in the last column costs 2+cols cycles.
- ram_ce is 0 in every cycle without a write. ram_addr/ram_data hold their last value when ram_ce=0.
- Reset mid-fill: the fill aborts, reset values apply, and a full CLEAR_ALL restarts after release.
- direction changes during WRITE or a fill take effect at the next IDLE.
- Address arithmetic: 10-bit row*cols+col, zero-extended to 12 bits. It never exceeds 749.

Test Plan:
- Release reset, direction=0 -> 750 ram_ce pulses, addr 0..749, data 16'h0F20, busy=1 during the fill, then in_ready=1 and cursor (0,0).
- Send 'A' (0x41) with attr_in=8'h1E loaded first -> one ram_ce with addr 0, data 16'h1E41, then cursor (1,0).
- Cursor at (49,14), send 'Z' -> write at addr 749, cursor (0,0), then 50 clear pulses at addr 0..49, data {attr,8'h20}.
- Cursor at (5,3), send 0x08 -> write at addr 154 (3*50+4) with data {attr,8'h20}, cursor (4,3). At (0,3), 0x08 -> no ram_ce, cursor unchanged.
- In IDLE, switch direction 0->1 -> cursor (0,0), 750-cell clear, then 'B' at cursor (29,0) writes addr 29 and the cursor wraps to (0,1) with a 30-cell clear at addr 30..59.
- Pulse clear_req during a CLEAR_LINE, and hold in_valid with 'C' -> the line fill completes, then CLEAR_ALL runs before 'C' is accepted. 'C' is then written at addr 0.
